// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer with core stall
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] val1_i,
    input  logic [WIDTH-1:0] val2_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t             state, state_next;
    logic [2:0]         op_f3;
    logic               neg_prod;
    logic               neg_rem;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [5:0]         cnt;

    logic               accept;
    logic               is_div_in;
    logic               a_signed, b_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf, special;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    // Operand decode at accept: MULHSU is the only mixed-sign case.
    always_comb begin
        is_div_in = funct3_i[2];
        a_signed  = is_div_in ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
        b_signed  = is_div_in ? ~funct3_i[0] : ~funct3_i[1];
        a_neg     = a_signed & val1_i[WIDTH-1];
        b_neg     = b_signed & val2_i[WIDTH-1];
        mag_a     = a_neg ? -val1_i : val1_i;
        mag_b     = b_neg ? -val2_i : val2_i;
        div_zero  = (val2_i == '0);
        div_ovf   = ~funct3_i[0] & (val1_i == {1'b1, {(WIDTH-1){1'b0}}}) & (val2_i == '1);
        special   = is_div_in & (div_zero | div_ovf);
        if (funct3_i[1])
            special_res = div_zero ? val1_i : '0;
        else
            special_res = div_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // acc_hi is the product high half / partial remainder, acc_lo the multiplier / quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
        prod_fix  = neg_prod ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = neg_prod ? -acc_lo : acc_lo;
        rem_fix   = neg_rem ? -acc_hi : acc_hi;
        if (op_f3[2])
            fix_res = op_f3[1] ? rem_fix : quo_fix;
        else if (op_f3[1:0] == 2'b00)
            fix_res = prod_fix[WIDTH-1:0];
        else
            fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end

    assign accept  = (state == IDLE) & start_i & ~flush_i;
    assign stall_o = accept | (state == CALC) | (state == FIX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (cnt == LAST_ITER) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i)
            state_next = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_o   <= 1'b0;
            result_o <= '0;
            op_f3    <= '0;
            neg_prod <= 1'b0;
            neg_rem  <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            cnt      <= '0;
        end else begin
            done_o <= (state_next == DONE);
            if (accept) begin
                op_f3    <= funct3_i;
                neg_prod <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                acc_hi   <= '0;
                acc_lo   <= is_div_in ? mag_a : mag_b;
                opnd     <= is_div_in ? mag_b : mag_a;
                cnt      <= '0;
                result_o <= special ? special_res : '0;
            end else if ((state == CALC) && !flush_i) begin
                cnt <= cnt + 6'd1;
                if (op_f3[2]) begin
                    // Non-negative trial means the divisor fits: keep the difference, quotient bit 1.
                    if (!div_trial[WIDTH]) begin
                        acc_hi <= div_trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                end
            end else if ((state == FIX) && !flush_i) begin
                result_o <= fix_res;
            end
        end
    end

endmodule
